unified_mem_arbiter: RTL

Shares one single-ported synchronous memory (1-cycle read latency) between the CPU instruction-fetch port and data port. Arbitrates per cycle: data wins by default, and a starvation counter forces instruction-fetch grants. Returns read data and write acks to the owning port, and handles out-of-range addresses locally. Sits between cpu_top's i_mem/d_mem ports and the unified RAM.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/arb_starve_ctr.sv | 38 +++
 rtl/unified_mem_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: owner encoding, arbitration
// states, response tag and the out-of-range fetch default.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  typedef enum logic {
    ST_DATA_PRI = 1'b0,
    ST_IF_FORCE = 1'b1
  } arb_state_e;

  localparam logic [31:0] OOR_IF_DATA_DEF = 32'hdeadbeef;

  typedef struct packed {
    owner_e port;
    logic   is_read;
    logic   oor;
  } rsp_tag_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while fetch waits; force_if flags
// that fetch must win the next contested cycle.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req_valid,
  input  logic if_grant,
  input  logic dm_grant,
  output logic force_if
);

  logic [3:0] cnt_q, cnt_d;
  arb_state_e state;

  always_comb begin
    cnt_d = cnt_q;
    if (!if_req_valid || if_grant) begin
      cnt_d = '0;
    end else if (dm_grant && (cnt_q < 4'(STARVE_LIMIT))) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // The FSM state is a pure function of the counter; it leaves ST_IF_FORCE
  // when the fetch grant clears the count.
  assign state    = (cnt_q == 4'(STARVE_LIMIT)) ? ST_IF_FORCE : ST_DATA_PRI;
  assign force_if = (state == ST_IF_FORCE);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported 1-cycle-latency RAM between instruction fetch and
// the data port; data wins unless fetch has been starved STARVE_LIMIT times.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_BYTES    = 4096,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [31:0] OOR_IF_DATA  = OOR_IF_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              dm_req_valid,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [DATA_W-1:0] dm_req_wdata,
  input  logic [3:0]        dm_req_wen,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_data,
  output logic              dm_rsp_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wen,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic     force_if, if_grant, dm_grant, if_ok, dm_ok;
  rsp_tag_t tag_d, tag_q;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return (addr < ADDR_W'(MEM_BYTES)) && (addr[1:0] == 2'b00);
  endfunction

  // Grants are held off during reset so nothing is recorded as in flight.
  assign if_grant     = rst_n && if_req_valid && (!dm_req_valid || force_if);
  assign dm_grant     = rst_n && dm_req_valid && !if_grant;
  assign if_req_ready = if_grant;
  assign dm_req_ready = dm_grant;
  assign if_ok        = addr_ok(if_req_addr);
  assign dm_ok        = addr_ok(dm_req_addr);

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_grant     (if_grant),
    .dm_grant     (dm_grant),
    .force_if     (force_if)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 4'b0000;
    tag_d     = '{port: OWN_NONE, is_read: 1'b0, oor: 1'b0};
    if (if_grant) begin
      tag_d = '{port: OWN_IF, is_read: 1'b1, oor: !if_ok};
      if (if_ok) begin
        mem_en   = 1'b1;
        mem_addr = if_req_addr;
      end
    end else if (dm_grant) begin
      tag_d = '{port: OWN_DM, is_read: (dm_req_wen == 4'b0000), oor: !dm_ok};
      if (dm_ok) begin
        mem_en    = 1'b1;
        mem_addr  = dm_req_addr;
        mem_wdata = dm_req_wdata;
        mem_wen   = dm_req_wen;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tag_q <= '{port: OWN_NONE, is_read: 1'b0, oor: 1'b0};
    else        tag_q <= tag_d;
  end

  // Responses are single-cycle pulses decoded from last cycle's owner; a
  // synchronous reset suppresses a response that would land in that cycle.
  always_comb begin
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    if_rsp_err   = 1'b0;
    dm_rsp_valid = 1'b0;
    dm_rsp_data  = '0;
    dm_rsp_err   = 1'b0;
    if (rst_n) begin
      unique case (tag_q.port)
        OWN_IF: begin
          if_rsp_valid = 1'b1;
          if_rsp_err   = tag_q.oor;
          if_rsp_data  = tag_q.oor ? DATA_W'(OOR_IF_DATA) : mem_rdata;
        end
        OWN_DM: begin
          dm_rsp_valid = 1'b1;
          dm_rsp_err   = tag_q.oor;
          if (tag_q.is_read && !tag_q.oor) dm_rsp_data = mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule
